dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory between two requesters: the pipeline MEM stage (CPU port) and a loader/DMA port used for program and data preload and debug readback.
- Performs round-robin arbitration, drives the memory's read/write strobes, address and write data, and routes the one-cycle-late read data back to the owning requester.
- Generates a CPU stall when the CPU loses arbitration.
- Sits between the MEM stage / loader and the data memory.

Parameters:
- AW, 32, address width of requester and memory address buses (word address).
- DW, 32, data width.
- DEPTH, 16, number of implemented memory words; addresses >= DEPTH are out of range.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- cpu_rd  in  1  CPU read request (MEM-stage MR)
- cpu_wr  in  1  CPU write request (MEM-stage MW)
- cpu_addr  in  AW  CPU word address
- cpu_wdata  in  DW  CPU store data
- cpu_gnt  out  1  CPU request accepted this cycle
- cpu_stall  out  1  CPU requested but not granted; pipeline must hold
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DW  CPU read data
- cpu_err  out  1  with cpu_rvalid or on a granted write: address out of range
- dma_rd, dma_wr, dma_addr, dma_wdata  in  1,1,AW,DW  loader request, same meaning as CPU
- dma_gnt, dma_rvalid, dma_rdata, dma_err  out  1,1,DW,1  loader responses, same meaning
- mem_mr  out  1  memory read strobe
- mem_mw  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, registered inside memory, valid one cycle after mem_mr

Behaviour:
- Request: req_x = x_rd | x_wr. If rd and wr are both set, it is treated as a write only; no read response is returned.
- Grant (combinational from requests and the last_gnt register):
  - Single requester: it is granted.
  - Both requesting: grant the port not recorded in last_gnt.
  - last_gnt updates to the granted port on every grant cycle.
  - At most one grant per cycle.
- cpu_stall = req_cpu & ~cpu_gnt (combinational).
- Memory drive (combinational mux from the granted port):
  - mem_addr and mem_wdata follow the granted port.
  - mem_mr = granted & rd & ~wr & in_range.
  - mem_mw = granted & wr & in_range.
  - With no grant: strobes 0, addr and wdata 0.
- in_range = addr < DEPTH. An out-of-range access never asserts a strobe:
  - Write: x_err pulses in the grant cycle.
  - Read: the response returns rdata = 0 with x_err = 1.
- Read latency is fixed at 1 cycle. A granted read in cycle N gives x_rvalid = 1 in cycle N+1, with x_rdata = mem_rdata (0 if out of range).
  - Response state: registered resp_valid, resp_owner, resp_err, captured at the grant edge.
  - Non-owner rdata is held at 0.
- Fully pipelined: a new grant may issue in the same cycle a response is returned, so back-to-back reads run at 1 per cycle.
- A write then a read to the same address in consecutive cycles returns the new data; this relies on the memory's write-before-next-read ordering.
- Write completion: a granted write is complete at the grant edge. There is no write response other than x_err.
- FSM: two states per response slot, IDLE -> RESP on a granted in-range or out-of-range read. RESP -> RESP if another read is granted, else RESP -> IDLE.
- Reset (rst_n = 0 at a rising edge):
  - last_gnt = DMA, so the CPU wins the first tie.
  - resp_valid = 0, resp_owner = CPU, resp_err = 0.
  - All rvalid and err outputs = 0; gnt and strobes follow the combinational rules.
  - Reset mid-operation drops any pending read response; no rvalid is issued for it.
- Requests while rst_n = 0 are ignored: gnt = 0, strobes = 0, cpu_stall = 0.
- Requesters must hold their request stable until granted.

Decomposition:
- Shared package dmem_pkg:
  - Owner encoding OWN_CPU = 1'b0, OWN_DMA = 1'b1.
  - Default widths AW_DEF, DW_DEF, DEPTH_DEF.
- One sub-module, rr_arb2: a 2-way round-robin arbiter with a last-grant register. It is reusable for the future I-mem/loader share.
- Response routing and the memory mux stay in dmem_arbiter.

Test Plan:
- Reset, then CPU write addr 3 data 0xDEADBEEF and next cycle CPU read addr 3 -> cpu_gnt both cycles, mem_mw then mem_mr, cpu_rvalid = 1 with cpu_rdata = 0xDEADBEEF one cycle after the read grant, cpu_stall = 0.
- After reset, CPU and DMA both read on the same cycle (addr 1 / addr 2), held -> CPU granted first, cpu_stall = 0; DMA granted the next cycle. dma_rvalid = 1 one cycle after its grant, and cpu_rvalid is never asserted for the DMA data.
- Both ports request continuously for 6 cycles -> grants alternate CPU, DMA, CPU, DMA...; cpu_stall = 1 exactly on the DMA-grant cycles.
- DMA write addr 20 (>= DEPTH) data 0x5 -> mem_mw = 0, dma_err pulses in the grant cycle. CPU read addr 16 -> mem_mr = 0, one cycle later cpu_rvalid = 1, cpu_err = 1, cpu_rdata = 0.
- CPU read granted, then rst_n = 0 on the next edge -> no cpu_rvalid afterwards; after release, the first tie goes to CPU.
- CPU asserts rd and wr together at addr 5 data 0x11 -> mem_mw = 1, mem_mr = 0, no cpu_rvalid; a later read of addr 5 returns 0x11.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared owner encoding, default widths and response-state type for the data-memory arbiter
package dmem_pkg;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    localparam int AW_DEF    = 32;
    localparam int DW_DEF    = 32;
    localparam int DEPTH_DEF = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } resp_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU, loader and data-memory signal bundle seen by the arbiter
interface dmem_arbiter_if #(
    parameter int AW = dmem_pkg::AW_DEF,
    parameter int DW = dmem_pkg::DW_DEF
);
    logic          cpu_rd;
    logic          cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_stall;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_err;

    logic          dma_rd;
    logic          dma_wr;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_gnt;
    logic          dma_rvalid;
    logic [DW-1:0] dma_rdata;
    logic          dma_err;

    logic          mem_mr;
    logic          mem_mw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  dma_rd, dma_wr, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata, cpu_err,
        output dma_gnt, dma_rvalid, dma_rdata, dma_err,
        output mem_mr, mem_mw, mem_addr, mem_wdata
    );

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output dma_rd, dma_wr, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata, cpu_err,
        input  dma_gnt, dma_rvalid, dma_rdata, dma_err,
        input  mem_mr, mem_mw, mem_addr, mem_wdata
    );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with a last-grant register
module rr_arb2
    import dmem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_gnt;

    // Bit index equals the owner encoding; requests are ignored while in reset.
    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            if (&req) begin
                gnt = (last_gnt == OWN_CPU) ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt <= OWN_DMA;
        end else if (|gnt) begin
            last_gnt <= gnt[1] ? OWN_DMA : OWN_CPU;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the single-port data memory between the CPU MEM stage and the loader
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    dmem_arbiter_if.slave   bus
);

    logic [1:0]    req;
    logic [1:0]    gnt;

    logic          sel_rd;
    logic          sel_wr;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_in_range;
    logic          rd_grant;
    logic          wr_err;

    resp_state_e   state_q, state_d;
    logic          owner_q, owner_d;
    logic          err_q, err_d;
    logic          resp_valid;
    logic [DW-1:0] resp_data;

    assign req = {bus.dma_rd | bus.dma_wr, bus.cpu_rd | bus.cpu_wr};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt)
    );

    assign bus.cpu_gnt   = gnt[OWN_CPU];
    assign bus.dma_gnt   = gnt[OWN_DMA];
    assign bus.cpu_stall = rst_n & req[OWN_CPU] & ~gnt[OWN_CPU];

    // Everything downstream sees zeros unless a port holds the grant.
    always_comb begin
        sel_rd    = 1'b0;
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (gnt[OWN_CPU]) begin
            sel_rd    = bus.cpu_rd;
            sel_wr    = bus.cpu_wr;
            sel_addr  = bus.cpu_addr;
            sel_wdata = bus.cpu_wdata;
        end else if (gnt[OWN_DMA]) begin
            sel_rd    = bus.dma_rd;
            sel_wr    = bus.dma_wr;
            sel_addr  = bus.dma_addr;
            sel_wdata = bus.dma_wdata;
        end
    end

    assign sel_in_range = sel_addr < AW'(DEPTH);
    assign rd_grant     = sel_rd & ~sel_wr;
    assign wr_err       = sel_wr & ~sel_in_range;

    assign bus.mem_mr    = rd_grant & sel_in_range;
    assign bus.mem_mw    = sel_wr & sel_in_range;
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = sel_wdata;

    // Every granted read, in or out of range, produces exactly one response next cycle.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: if (rd_grant)  state_d = ST_RESP;
            ST_RESP: if (!rd_grant) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (rd_grant) begin
            owner_d = gnt[OWN_DMA] ? OWN_DMA : OWN_CPU;
            err_d   = ~sel_in_range;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_CPU;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            err_q   <= err_d;
        end
    end

    // Gating with rst_n keeps a response pending at reset assertion from ever surfacing.
    assign resp_valid = rst_n & (state_q == ST_RESP);
    assign resp_data  = err_q ? '0 : bus.mem_rdata;

    assign bus.cpu_rvalid = resp_valid & (owner_q == OWN_CPU);
    assign bus.dma_rvalid = resp_valid & (owner_q == OWN_DMA);
    assign bus.cpu_rdata  = bus.cpu_rvalid ? resp_data : '0;
    assign bus.dma_rdata  = bus.dma_rvalid ? resp_data : '0;
    assign bus.cpu_err    = (bus.cpu_rvalid & err_q) | (gnt[OWN_CPU] & wr_err);
    assign bus.dma_err    = (bus.dma_rvalid & err_q) | (gnt[OWN_DMA] & wr_err);

endmodule
